// File: rtl/seg_display_arbiter.sv
// Time-shares a seven-segment display between score, timer and a preempting message.
// Optional message blink is built when SEG_ARB_BLINK_EN is defined.
module seg_display_arbiter #(
   parameter int unsigned numDigits   = 4,
   parameter int unsigned ROT_TICKS   = 3000,
   parameter int unsigned MSG_TICKS   = 2000,
   parameter int unsigned BLINK_TICKS = 250
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [numDigits*4-1:0]   score_val,
   input  logic [numDigits*4-1:0]   time_val,
   input  logic                     msg_req,
   input  logic [numDigits*4-1:0]   msg_val,
   output logic [numDigits*4-1:0]   disp_val,
   output logic                     disp_en,
   output logic [1:0]               src_sel,
   output logic                     msg_busy
);

   localparam int unsigned W    = numDigits * 4;
   localparam int unsigned MAXT = (ROT_TICKS > MSG_TICKS) ? ROT_TICKS : MSG_TICKS;
   localparam int unsigned CW   = $clog2(MAXT + 1);
   localparam logic [CW-1:0] ROT_LAST = CW'(ROT_TICKS - 1);
   localparam logic [CW-1:0] MSG_LAST = CW'(MSG_TICKS - 1);

   if (ROT_TICKS < 1 || MSG_TICKS < 1 || BLINK_TICKS < 1) begin : g_bad_param
      $error("seg_display_arbiter: tick counts must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_SCORE = 2'd0,
      ST_TIME  = 2'd1,
      ST_MSG   = 2'd2
   } state_t;

   state_t          state;
   state_t          ret_state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    msg_latch;

`ifdef SEG_ARB_BLINK_EN
   localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   logic [BW-1:0]   bcnt;
   logic            vis;
`endif

   // Outputs are registered from the state held during the previous cycle,
   // so src_sel, msg_busy, disp_en and disp_val always move together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_SCORE;
         ret_state <= ST_SCORE;
         cnt       <= '0;
         msg_latch <= '0;
         disp_val  <= '0;
         disp_en   <= 1'b0;
         src_sel   <= 2'd0;
         msg_busy  <= 1'b0;
`ifdef SEG_ARB_BLINK_EN
         bcnt      <= '0;
         vis       <= 1'b1;
`endif
      end else begin
         src_sel  <= state;
         msg_busy <= (state == ST_MSG);
         case (state)
            ST_SCORE: disp_val <= score_val;
            ST_TIME:  disp_val <= time_val;
            default:  disp_val <= msg_latch;
         endcase
`ifdef SEG_ARB_BLINK_EN
         disp_en <= (state == ST_MSG) ? vis : 1'b1;
`else
         disp_en <= 1'b1;
`endif

         case (state)
            ST_SCORE, ST_TIME: begin
               if (msg_req) begin
                  msg_latch <= msg_val;
                  ret_state <= state;
                  state     <= ST_MSG;
                  cnt       <= '0;
`ifdef SEG_ARB_BLINK_EN
                  bcnt      <= '0;
                  vis       <= 1'b1;
`endif
               end else if (tick) begin
                  if (cnt == ROT_LAST) begin
                     cnt   <= '0;
                     state <= (state == ST_SCORE) ? ST_TIME : ST_SCORE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_MSG: begin
               if (msg_req) begin
                  msg_latch <= msg_val;
                  cnt       <= '0;
`ifdef SEG_ARB_BLINK_EN
                  bcnt      <= '0;
                  vis       <= 1'b1;
`endif
               end else if (tick) begin
                  if (cnt == MSG_LAST) begin
                     cnt   <= '0;
                     state <= ret_state;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
`ifdef SEG_ARB_BLINK_EN
                  if (bcnt == BLINK_LAST) begin
                     bcnt <= '0;
                     vis  <= ~vis;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
`endif
               end
            end
            default: begin
               state <= ST_SCORE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Time-shares the board's n-digit seven-segment display between three hex/BCD sources: game score, countdown timer, and a one-shot message such as a banner or bonus value. It rotates between score and timer and lets a message request preempt either for a fixed time. Its outputs drive the seven-segment driver's `in` and `en` inputs directly. It sits between the game FSM / score logic and the display driver.

Parameters:
numDigits, 4, number of display digits; every value bus is numDigits*4 bits
ROT_TICKS, 3000, tick count each of SCORE/TIME is shown before rotating (≥1)
MSG_TICKS, 2000, tick count a message is shown (≥1)
BLINK_TICKS, 250, half-period in ticks of message blink (used only with BLINK_EN, ≥1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  single-cycle timebase strobe (e.g. 1 ms); all durations count ticks
score_val  in  numDigits*4  score digits, nibble k = digit k
time_val  in  numDigits*4  timer digits
msg_req  in  1  single-cycle request to show msg_val
msg_val  in  numDigits*4  message digits, sampled on the msg_req cycle
disp_val  out  numDigits*4  value to display driver `in`
disp_en  out  1  display driver enable
src_sel  out  2  current source: 0=SCORE, 1=TIME, 2=MSG (3 never driven)
msg_busy  out  1  high while in MSG state

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous, active-high.
- Reset values: state=SCORE, ret_state=SCORE, tick counter=0, blink counter=0, msg latch=0, disp_val=0, disp_en=0, src_sel=0, msg_busy=0.
- All outputs are registered. disp_en goes to 1 on the first clk edge after rst deasserts and stays 1, except for blink (see Optional Feature).
- disp_val latency: 1 cycle. disp_val(n+1) = selected source at cycle n.
- SCORE and TIME select the live input buses (score_val, time_val). MSG selects the message latch.
- States: SCORE, TIME, MSG.
- SCORE and TIME:
  - Counter increments on tick.
  - On the tick where counter == ROT_TICKS-1, the counter clears and the state toggles SCORE<->TIME.
- msg_req in SCORE or TIME:
  - msg_val is latched.
  - ret_state := current state.
  - State goes to MSG and the counter clears.
  - This has priority over a coincident rotation tick: the rotation is discarded and ret_state is the pre-rotation state.
- MSG:
  - Counter increments on tick.
  - On the tick where counter == MSG_TICKS-1, the state goes to ret_state and the counter clears, giving the returned-to source a full ROT_TICKS.
- msg_req while in MSG:
  - The new msg_val is latched and the counter clears (retrigger).
  - ret_state is unchanged.
  - This has priority over a coincident expiry tick.
- src_sel and msg_busy follow the state, registered alongside disp_val on the same cycle.
- tick held high continuously is legal: each high cycle counts as one tick.
- Counter width: $clog2 of max(ROT_TICKS, MSG_TICKS)+1. The counter never exceeds its terminal value.
- rst asserted mid-message: immediate return to reset values. The message is lost and no return occurs.
- Input changes on score_val/time_val propagate within 1 cycle while that source is selected.

Optional Feature:
Macro SEG_ARB_BLINK_EN.
- Defined:
  - In MSG, a blink counter counts ticks. On the tick where it equals BLINK_TICKS-1, it clears and disp_en toggles.
  - On MSG entry or retrigger, the blink counter clears and disp_en = 1 (message starts visible).
  - On MSG exit, disp_en = 1 on the same cycle src_sel changes.
  - Outside MSG, disp_en stays 1.
- Undefined: no blink counter exists; disp_en is 1 at all times after reset.

Test Plan:
- Reset/startup: rst=1 with score_val=16'h1234, then release → disp_val=0 and disp_en=0 while in reset. One cycle after release: disp_en=1, disp_val=16'h1234, src_sel=0.
- Rotation: ROT_TICKS=4, tick every cycle, score=16'h0042, time=16'h0099 → src_sel sequence 0,0,0,0,1,1,1,1,0. disp_val alternates 0042/0099 with no gap cycles.
- Preemption and return:
  - Setup: ROT_TICKS=4, MSG_TICKS=3. In TIME after 2 ticks, pulse msg_req with msg_val=16'hBEEF.
  - Expect: next cycle src_sel=2, msg_busy=1, disp_val=BEEF.
  - Then after 3 ticks: src_sel=1 held for a full 4 ticks.
- Coincident events:
  - msg_req on the SCORE rotation tick → MSG entered, and the return goes to SCORE, not TIME.
  - msg_req (val 16'hCAFE) on the MSG expiry tick → stays in MSG showing CAFE, counter restarted.
- Live update / mid-message reset:
  - Change score_val while in SCORE → disp_val updates the next cycle.
  - Assert rst mid-MSG → all outputs 0 immediately (asynchronous). After release, state=SCORE.
- Blink (SEG_ARB_BLINK_EN, BLINK_TICKS=2, MSG_TICKS=8, tick every cycle) → disp_en in MSG reads 1,1,0,0,1,1,0,0. On return to SCORE, disp_en=1. Without the macro, disp_en=1 throughout.
